// File: rtl/avalon_pio_pkg.sv
// rtl/avalon_pio_pkg.sv - register map and edge-type encodings for the Avalon PIO
package avalon_pio_pkg;
   localparam logic [2:0] ADDR_DATA        = 3'd0;
   localparam logic [2:0] ADDR_DIRECTION   = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK     = 3'd2;
   localparam logic [2:0] ADDR_EDGECAPTURE = 3'd3;
   localparam logic [2:0] ADDR_OUTSET      = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;
endpackage

// File: rtl/avalon_pio_bidir_if.sv
// rtl/avalon_pio_bidir_if.sv - Avalon-MM slave bus bundle for the PIO register file
interface avalon_pio_bidir_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_input_sync.sv
// rtl/pio_input_sync.sv - pad synchroniser, one delay stage and per-bit edge detector
module pio_input_sync
   import avalon_pio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int EDGE_TYPE   = EDGE_RISING,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_pio_in,
   output logic [WIDTH-1:0] o_sync_in,
   output logic [WIDTH-1:0] o_edge
);
   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [WIDTH-1:0] r_sync_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
         r_sync_d <= '0;
      end else begin
         r_sync[0] <= i_pio_in;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_sync_d <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_sync_in = r_sync[SYNC_STAGES-1];

   // Runs on every bit regardless of direction so a driven SCL can be watched for stretching
   always_comb begin
      case (EDGE_TYPE)
         EDGE_FALLING: o_edge = ~o_sync_in & r_sync_d;
         EDGE_ANY:     o_edge = o_sync_in ^ r_sync_d;
         default:      o_edge = o_sync_in & ~r_sync_d;
      endcase
   end
endmodule

// File: rtl/avalon_pio_bidir.sv
// rtl/avalon_pio_bidir.sv - bidirectional Avalon-MM PIO with edge capture and irq
// Optional atomic OUTSET/OUTCLEAR registers enabled by macro PIO_OUTSET_CLEAR_EN.
module avalon_pio_bidir
   import avalon_pio_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] RESET_DIR   = '0,
   parameter int               EDGE_TYPE   = EDGE_RISING,
   parameter int               SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   avalon_pio_bidir_if.slave  bus,
   input  logic [WIDTH-1:0]   pio_in,
   output logic [WIDTH-1:0]   pio_out,
   output logic [WIDTH-1:0]   pio_oe,
   output logic               irq
);
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_dir;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_cap;
   logic             r_irq;

   logic             w_wr;
   logic [WIDTH-1:0] w_wdata;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_sync_in;
   logic [WIDTH-1:0] w_edge;

   pio_input_sync #(
      .WIDTH       (WIDTH),
      .EDGE_TYPE   (EDGE_TYPE),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .reset     (reset),
      .i_pio_in  (pio_in),
      .o_sync_in (w_sync_in),
      .o_edge    (w_edge)
   );

   assign w_wr    = bus.chipselect & ~bus.write_n;
   assign w_wdata = bus.writedata[WIDTH-1:0];
   assign w_clr   = (w_wr && bus.address == ADDR_EDGECAPTURE) ? w_wdata : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data <= RESET_VALUE;
         r_dir  <= RESET_DIR;
         r_mask <= '0;
         r_cap  <= '0;
         r_irq  <= 1'b0;
      end else begin
         // A fresh edge on a bit being cleared in the same cycle keeps the bit set
         r_cap <= w_edge | (r_cap & ~w_clr);
         r_irq <= |(r_cap & r_mask);
         if (w_wr) begin
            case (bus.address)
               ADDR_DATA:      r_data <= w_wdata;
               ADDR_DIRECTION: r_dir  <= w_wdata;
               ADDR_IRQMASK:   r_mask <= w_wdata;
`ifdef PIO_OUTSET_CLEAR_EN
               ADDR_OUTSET:    r_data <= r_data | w_wdata;
               ADDR_OUTCLEAR:  r_data <= r_data & ~w_wdata;
`else
`endif
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         ADDR_DATA:                  bus.readdata = 32'(w_sync_in);
         ADDR_DIRECTION:             bus.readdata = 32'(r_dir);
         ADDR_IRQMASK:               bus.readdata = 32'(r_mask);
         ADDR_EDGECAPTURE:           bus.readdata = 32'(r_cap);
         ADDR_OUTSET, ADDR_OUTCLEAR: bus.readdata = '0;
         default:                    bus.readdata = '0;
      endcase
   end

   assign pio_out = r_data;
   assign pio_oe  = r_dir;
   assign irq     = r_irq;
endmodule

// File: tb/tb_avalon_pio_bidir.sv
// tb/tb_avalon_pio_bidir.sv - randomized self-checking bench for avalon_pio_bidir
module tb_avalon_pio_bidir;
   logic clk = 1'b0;
   logic reset;
   logic [7:0] pio_in;
   logic [7:0] pout_a, pout_b, poe_a, poe_b;
   logic       irq_a, irq_b;
   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   avalon_pio_bidir_if bus_a ();
   avalon_pio_bidir_if bus_b ();

   avalon_pio_bidir #(.WIDTH(8), .RESET_VALUE(8'hA5), .RESET_DIR(8'h0F),
                      .EDGE_TYPE(0), .SYNC_STAGES(2)) u_dut_a (
      .clk(clk), .reset(reset), .bus(bus_a.slave), .pio_in(pio_in),
      .pio_out(pout_a), .pio_oe(poe_a), .irq(irq_a));

   avalon_pio_bidir #(.WIDTH(8), .RESET_VALUE(8'h10), .RESET_DIR(8'hFF),
                      .EDGE_TYPE(2), .SYNC_STAGES(3)) u_dut_b (
      .clk(clk), .reset(reset), .bus(bus_b.slave), .pio_in(pio_in),
      .pio_out(pout_b), .pio_oe(poe_b), .irq(irq_b));

   function automatic logic [7:0] rv(int k);   return (k == 0) ? 8'hA5 : 8'h10; endfunction
   function automatic logic [7:0] rdir(int k); return (k == 0) ? 8'h0F : 8'hFF; endfunction
   function automatic int et(int k);           return (k == 0) ? 0 : 2; endfunction
   function automatic int ss(int k);           return (k == 0) ? 2 : 3; endfunction
   function automatic logic [7:0] dout(int k); return (k == 0) ? pout_a : pout_b; endfunction
   function automatic logic [7:0] doe(int k);  return (k == 0) ? poe_a : poe_b; endfunction
   function automatic logic dirq(int k);       return (k == 0) ? irq_a : irq_b; endfunction
   function automatic logic [31:0] drd(int k); return (k == 0) ? bus_a.readdata : bus_b.readdata; endfunction

   // Reference model: pad samples kept newest-first; sync_in is the sample taken ss clocks ago
   logic [7:0] hist [$];
   logic [7:0] m_data [2];
   logic [7:0] m_dir  [2];
   logic [7:0] m_mask [2];
   logic [7:0] m_cap  [2];
   logic       m_irq  [2];

   function automatic logic [7:0] sync_of(int s, int back);
      if (s - 1 + back < hist.size()) return hist[s - 1 + back];
      return 8'h00;
   endfunction

   function automatic logic [7:0] edge_of(int t, logic [7:0] cur, logic [7:0] prev);
      case (t)
         0:       return cur & ~prev;
         1:       return ~cur & prev;
         default: return cur ^ prev;
      endcase
   endfunction

   function automatic logic [31:0] mread(int k, logic [2:0] a);
      case (a)
         3'd0:    return {24'h0, sync_of(ss(k), 0)};
         3'd1:    return {24'h0, m_dir[k]};
         3'd2:    return {24'h0, m_mask[k]};
         3'd3:    return {24'h0, m_cap[k]};
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         hist.delete();
         for (int k = 0; k < 2; k++) begin
            m_data[k] <= rv(k);
            m_dir[k]  <= rdir(k);
            m_mask[k] <= 8'h00;
            m_cap[k]  <= 8'h00;
            m_irq[k]  <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_cap[k] <= edge_of(et(k), sync_of(ss(k), 0), sync_of(ss(k), 1)) |
                        (m_cap[k] & ~((bus_a.chipselect && !bus_a.write_n && bus_a.address == 3'd3)
                                      ? bus_a.writedata[7:0] : 8'h00));
            m_irq[k] <= |(m_cap[k] & m_mask[k]);
            if (bus_a.chipselect && !bus_a.write_n) begin
               case (bus_a.address)
                  3'd0: m_data[k] <= bus_a.writedata[7:0];
                  3'd1: m_dir[k]  <= bus_a.writedata[7:0];
                  3'd2: m_mask[k] <= bus_a.writedata[7:0];
`ifdef PIO_OUTSET_CLEAR_EN
                  3'd4: m_data[k] <= m_data[k] | bus_a.writedata[7:0];
                  3'd5: m_data[k] <= m_data[k] & ~bus_a.writedata[7:0];
`endif
                  default: ;
               endcase
            end
         end
         hist.push_front(pio_in);
         if (hist.size() > 8) void'(hist.pop_back());
      end
   end

   task automatic bus_set(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
      bus_a.chipselect = cs; bus_a.write_n = wn; bus_a.address = a; bus_a.writedata = d;
      bus_b.chipselect = cs; bus_b.write_n = wn; bus_b.address = a; bus_b.writedata = d;
   endtask

   task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk); bus_set(1'b1, 1'b0, a, d);
      @(negedge clk); bus_set(1'b0, 1'b1, a, 32'h0);
   endtask

   task automatic test_reset();
      reset = 1'b1; pio_in = 8'h00; bus_set(1'b0, 1'b1, 3'd3, 32'h0);
      repeat (3) @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         n_total += 4;
         if (dout(k) !== rv(k)) $display("FAIL reset_pio_out inst%0d got %h expected %h", k, dout(k), rv(k)); else n_pass++;
         if (doe(k) !== rdir(k)) $display("FAIL reset_pio_oe inst%0d got %h expected %h", k, doe(k), rdir(k)); else n_pass++;
         if (dirq(k) !== 1'b0) $display("FAIL reset_irq inst%0d got %b expected 0", k, dirq(k)); else n_pass++;
         if (drd(k) !== 32'h0) $display("FAIL reset_edgecap inst%0d got %h expected 0", k, drd(k)); else n_pass++;
      end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_data_rw();
      write_reg(3'd0, 32'hFFFF_FF3C);
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (dout(k) !== 8'h3C) $display("FAIL data_write inst%0d got %h expected 3c", k, dout(k)); else n_pass++;
      end
      write_reg(3'd1, 32'h0000_01C3);
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (doe(k) !== 8'hC3) $display("FAIL dir_write inst%0d got %h expected c3", k, doe(k)); else n_pass++;
      end
      pio_in = 8'h81;
      repeat (4) @(negedge clk);
      bus_set(1'b0, 1'b1, 3'd0, 32'h0); #1;
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (drd(k) !== 32'h0000_0081) $display("FAIL data_read inst%0d got %h expected 00000081", k, drd(k)); else n_pass++;
      end
   endtask

   task automatic test_edge_irq();
      write_reg(3'd2, 32'h04);
      write_reg(3'd3, 32'hFF);
      pio_in[2] = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk); bus_set(1'b0, 1'b1, 3'd3, 32'h0); #1;
         n_total += 4;
         if (bus_a.readdata !== ((c >= 3) ? 32'h4 : 32'h0))
            $display("FAIL cap_latency cycle%0d got %h expected %h", c, bus_a.readdata, (c >= 3) ? 32'h4 : 32'h0);
         else n_pass++;
         if (irq_a !== (c >= 4)) $display("FAIL irq_latency cycle%0d got %b expected %b", c, irq_a, c >= 4); else n_pass++;
         if (bus_b.readdata !== mread(1, 3'd3)) $display("FAIL cap_model_b cycle%0d got %h expected %h", c, bus_b.readdata, mread(1, 3'd3)); else n_pass++;
         if (irq_b !== m_irq[1]) $display("FAIL irq_model_b cycle%0d got %b expected %b", c, irq_b, m_irq[1]); else n_pass++;
      end
      write_reg(3'd3, 32'h04);
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (dirq(k) !== 1'b1) $display("FAIL irq_hold_after_clear inst%0d got %b expected 1", k, dirq(k)); else n_pass++;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (dirq(k) !== 1'b0) $display("FAIL irq_drop_after_clear inst%0d got %b expected 0", k, dirq(k)); else n_pass++;
      end
   endtask

   task automatic test_simultaneous();
      pio_in[2] = 1'b0;
      repeat (5) @(negedge clk);
      write_reg(3'd3, 32'hFF);
      pio_in[2] = 1'b1;
      @(negedge clk);
      @(negedge clk); bus_set(1'b1, 1'b0, 3'd3, 32'h04);
      @(negedge clk); bus_set(1'b0, 1'b1, 3'd3, 32'h0); #1;
      n_total += 2;
      if (bus_a.readdata !== 32'h4) $display("FAIL edge_beats_clear got %h expected 00000004", bus_a.readdata); else n_pass++;
      if (bus_b.readdata !== mread(1, 3'd3)) $display("FAIL edge_clear_model_b got %h expected %h", bus_b.readdata, mread(1, 3'd3)); else n_pass++;
   endtask

   task automatic test_any_edge();
      pio_in[0] = 1'b0;
      repeat (6) @(negedge clk);
      write_reg(3'd3, 32'hFF);
      for (int p = 0; p < 2; p++) begin
         pio_in[0] = (p == 0);
         repeat (5) @(negedge clk);
         bus_set(1'b0, 1'b1, 3'd3, 32'h0); #1;
         n_total += 2;
         if (bus_b.readdata[0] !== 1'b1) $display("FAIL any_edge_capture pulse%0d got %b expected 1", p, bus_b.readdata[0]); else n_pass++;
         if (bus_a.readdata[0] !== (p == 0)) $display("FAIL rising_only pulse%0d got %b expected %b", p, bus_a.readdata[0], p == 0); else n_pass++;
         write_reg(3'd3, 32'h01); #1;
         n_total++;
         if (bus_b.readdata[0] !== 1'b0) $display("FAIL any_edge_clear pulse%0d got %b expected 0", p, bus_b.readdata[0]); else n_pass++;
      end
   endtask

   task automatic test_outset_clear();
      logic [7:0] e1, e2;
`ifdef PIO_OUTSET_CLEAR_EN
      e1 = 8'h11; e2 = 8'h01;
`else
      e1 = 8'h10; e2 = 8'h10;
`endif
      write_reg(3'd0, 32'h10);
      write_reg(3'd4, 32'h01);
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (dout(k) !== e1) $display("FAIL outset inst%0d got %h expected %h", k, dout(k), e1); else n_pass++;
      end
      write_reg(3'd5, 32'h10);
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (dout(k) !== e2) $display("FAIL outclear inst%0d got %h expected %h", k, dout(k), e2); else n_pass++;
      end
      for (int a = 4; a < 8; a++) begin
         bus_set(1'b0, 1'b1, 3'(a), 32'h0); #1;
         n_total++;
         if (bus_a.readdata !== 32'h0) $display("FAIL reserved_read addr%0d got %h expected 0", a, bus_a.readdata); else n_pass++;
      end
   endtask

   task automatic test_random(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            n_total += 3;
            if (dout(k) !== m_data[k]) $display("FAIL rand_pio_out inst%0d cyc%0d got %h expected %h", k, i, dout(k), m_data[k]); else n_pass++;
            if (doe(k) !== m_dir[k]) $display("FAIL rand_pio_oe inst%0d cyc%0d got %h expected %h", k, i, doe(k), m_dir[k]); else n_pass++;
            if (dirq(k) !== m_irq[k]) $display("FAIL rand_irq inst%0d cyc%0d got %b expected %b", k, i, dirq(k), m_irq[k]); else n_pass++;
         end
         if ($urandom_range(0, 2) == 0) pio_in = 8'($urandom);
         bus_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
         #1;
         for (int k = 0; k < 2; k++) begin
            n_total++;
            if (drd(k) !== mread(k, bus_a.address))
               $display("FAIL rand_readdata inst%0d cyc%0d addr%0d got %h expected %h", k, i, bus_a.address, drd(k), mread(k, bus_a.address));
            else n_pass++;
         end
      end
      @(negedge clk); bus_set(1'b0, 1'b1, 3'd0, 32'h0);
   endtask

   task automatic test_reset_mid();
      pio_in = 8'hFF;
      @(negedge clk); #2 reset = 1'b1; #1;
      for (int k = 0; k < 2; k++) begin
         n_total += 3;
         if (dout(k) !== rv(k)) $display("FAIL midreset_pio_out inst%0d got %h expected %h", k, dout(k), rv(k)); else n_pass++;
         if (doe(k) !== rdir(k)) $display("FAIL midreset_pio_oe inst%0d got %h expected %h", k, doe(k), rdir(k)); else n_pass++;
         if (dirq(k) !== 1'b0) $display("FAIL midreset_irq inst%0d got %b expected 0", k, dirq(k)); else n_pass++;
      end
      @(negedge clk); reset = 1'b0;
      write_reg(3'd2, 32'hFF);
      test_random(60);
   endtask

   initial begin
      test_reset();
      test_data_rw();
      test_edge_irq();
      test_simultaneous();
      test_any_edge();
      test_outset_clear();
      test_random(400);
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
